// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, datapath widths, BCD stage states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package calc_pkg;

  // basic_calculator opcodes
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CALC_OPERAND_W = 8;
  localparam int CALC_RESULT_W  = 16;

  // Five digits cover the full 16-bit result range (max 65535)
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Digit is at most 9 on entry, so the 4-bit sum never wraps
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/calc_result_bcd.sv
// Binary-to-BCD converter for calculator results, with significant-digit count.
// Latency: WIDTH cycles after acceptance for normal results; error results are ready right after acceptance.
// Backpressure: one result in flight; in_ready only in IDLE, output held in DONE until out_ready.
module calc_result_bcd
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_RESULT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      result,
  input  logic                  error_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            ndigits,
  output logic                  out_error,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  bcd_state_t        state_q;
  bcd_state_t        state_d;
  logic [SH_W-1:0]   sh_q;
  logic [SH_W-1:0]   sh_shift;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  fin_digits;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [2:0]        nd_q;
  logic [2:0]        nd_next;
  logic              err_q;
  logic              last_shift;

  // All digits are corrected in parallel from the current register contents
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (sh_q[WIDTH + 4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

  assign sh_shift   = {adj, sh_q[WIDTH-1:0]} << 1;
  assign fin_digits = sh_shift[SH_W-1 -: BCD_W];
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  // Significant digits: position of the highest nonzero digit, at least one
  always_comb begin
    nd_next = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (fin_digits[4*i +: 4] != 4'd0) begin
        nd_next = 3'(i + 1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = error_flag ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, shift-and-add-3 datapath and output latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      nd_q  <= 3'd1;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (error_flag) begin
              err_q <= 1'b1;
              bcd_q <= '0;
              nd_q  <= 3'd1;
            end else begin
              err_q <= 1'b0;
              sh_q  <= {{BCD_W{1'b0}}, result};
              cnt_q <= '0;
            end
          end
        end
        SHIFT: begin
          sh_q  <= sh_shift;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_shift) begin
            bcd_q <= fin_digits;
            nd_q  <= nd_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign ndigits   = nd_q;
  assign out_error = err_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed test of calc_result_bcd: conversion values, latency, error bypass, handshakes, reset.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready low in DONE and in_valid held during SHIFT.
module tb_calc_result_bcd;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic        error_flag;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd;
  logic [2:0]  ndigits;
  logic        out_error;
  logic        busy;

  int checks;
  int errors;

  calc_result_bcd dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .error_flag (error_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bcd        (bcd),
    .ndigits    (ndigits),
    .out_error  (out_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one result and step past its acceptance edge (E0); leaves in_valid low
  task automatic start(input logic [15:0] res, input logic err);
    result     = res;
    error_flag = err;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  // Let DONE drain with a single out_ready edge
  task automatic release_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, bcd, ndigits, out_error} !== {1'b1, 1'b0, 1'b0, 20'h0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b bcd=%h nd=%0d err=%b, want rdy=1 vld=0 busy=0 bcd=00000 nd=1 err=0",
               in_ready, out_valid, busy, bcd, ndigits, out_error);
    end
  endtask

  // result 15 (ADD 10+5): 16 cycles after acceptance
  task automatic test_basic();
    int lat;
    start(16'd15, 1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b in_ready=%b, want busy=1 in_ready=0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles, want 16", lat);
    end
    checks++;
    if (bcd !== 20'h00015 || ndigits !== 3'd2 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_value: bcd=%h nd=%0d err=%b, want 00015 2 0", bcd, ndigits, out_error);
    end
    release_output();
  endtask

  task automatic test_boundaries();
    logic [15:0] vin [3]  = '{16'd65535, 16'd0, 16'd12};
    logic [19:0] vbcd [3] = '{20'h65535, 20'h00000, 20'h00012};
    logic [2:0]  vnd [3]  = '{3'd5, 3'd1, 3'd2};
    int lat;
    for (int k = 0; k < 3; k++) begin
      start(vin[k], 1'b0);
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 16 || bcd !== vbcd[k] || ndigits !== vnd[k] || out_error !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d: lat=%0d bcd=%h nd=%0d err=%b, want lat=16 bcd=%h nd=%0d err=0",
                 vin[k], lat, bcd, ndigits, out_error, vbcd[k], vnd[k]);
      end
      release_output();
    end
  endtask

  // DIV 8/0: error result is presented right after the acceptance edge
  task automatic test_error();
    start(16'hDEAD, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_error !== 1'b1 || bcd !== 20'h0 || ndigits !== 3'd1) begin
      errors++;
      $display("FAIL error_path: vld=%b err=%b bcd=%h nd=%0d, want 1 1 00000 1", out_valid, out_error, bcd, ndigits);
    end
    release_output();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL error_release: in_ready=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start(16'd4, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== 20'h00004 || ndigits !== 3'd1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0 || lat !== 16) begin
      errors++;
      $display("FAIL backpressure_hold: %0d unstable cycles lat=%0d vld=%b rdy=%b bcd=%h, want 0 16 1 0 00004",
               bad, lat, out_valid, in_ready, bcd);
    end
    release_output();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    start(16'd9999, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, bcd, ndigits, out_error} !== {1'b1, 1'b0, 1'b0, 20'h0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_state: rdy=%b vld=%b busy=%b bcd=%h nd=%0d err=%b, want 1 0 0 00000 1 0",
               in_ready, out_valid, busy, bcd, ndigits, out_error);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: out_valid seen %0d cycles, want 0", seen);
    end
    start(16'd5, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16 || bcd !== 20'h00005 || ndigits !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid_next: lat=%0d bcd=%h nd=%0d, want 16 00005 1", lat, bcd, ndigits);
    end
    release_output();
  endtask

  task automatic test_busy_input();
    int lat;
    start(16'd321, 1'b0);
    in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      result = result + 16'd1111;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 16 || bcd !== 20'h00321 || ndigits !== 3'd3) begin
      errors++;
      $display("FAIL busy_input: lat=%0d bcd=%h nd=%0d, want 16 00321 3", lat, bcd, ndigits);
    end
    in_valid = 1'b0;
    release_output();
  endtask

  // out_ready tied high: IDLE back to IDLE takes 18 edges (normal) and 2 (error), acceptance included
  task automatic test_back_to_back();
    int edges;
    out_ready = 1'b1;
    start(16'd7, 1'b0);
    edges = 1;
    while (!in_ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges !== 18 || bcd !== 20'h00007) begin
      errors++;
      $display("FAIL cycle_normal: %0d edges bcd=%h, want 18 00007", edges, bcd);
    end
    start(16'd1, 1'b1);
    edges = 1;
    while (!in_ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges !== 2 || out_error !== 1'b1) begin
      errors++;
      $display("FAIL cycle_error: %0d edges err=%b, want 2 1", edges, out_error);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    result     = '0;
    error_flag = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_busy_input();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
